// File: rtl/axi_inorder_responder_pkg.sv
// Shared AXI4+ATOP types and codes for the in-order terminal responder.
// Provides the response codes, ATOP bit positions and default request/response
// structs that the responder and its surroundings agree on.
package axi_inorder_responder_pkg;

  typedef logic [1:0] resp_t;
  typedef logic [7:0] len_t;
  typedef logic [5:0] atop_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_DECERR = 2'b11;

  // Bit of aw.atop that marks an atomic needing an R response.
  localparam int unsigned ATOP_R_RESP = 5;
  localparam atop_t       ATOP_NONE   = 6'b000000;

  localparam int unsigned DefIdWidth   = 4;
  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefDataWidth = 64;

  typedef struct packed {
    logic [DefIdWidth-1:0]   id;
    logic [DefAddrWidth-1:0] addr;
    len_t                    len;
    logic [2:0]              size;
    logic [1:0]              burst;
    atop_t                   atop;
  } aw_chan_t;

  typedef struct packed {
    logic [DefDataWidth-1:0]   data;
    logic [DefDataWidth/8-1:0] strb;
    logic                      last;
  } w_chan_t;

  typedef struct packed {
    logic [DefIdWidth-1:0]   id;
    logic [DefAddrWidth-1:0] addr;
    len_t                    len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } ar_chan_t;

  typedef struct packed {
    logic [DefIdWidth-1:0] id;
    resp_t                 resp;
    logic                  user;
  } b_chan_t;

  typedef struct packed {
    logic [DefIdWidth-1:0]   id;
    logic [DefDataWidth-1:0] data;
    resp_t                   resp;
    logic                    last;
    logic                    user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_default_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_default_t;

endpackage

// File: rtl/axi_inorder_responder_fifo.sv
// Small non-fall-through synchronous FIFO used for the responder's
// tracking queues. A push on a full FIFO is accepted only when a pop
// frees the head slot in the same cycle.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         dtype = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push,
  input  dtype push_data,
  input  logic pop,
  output dtype head,
  output logic full,
  output logic empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  localparam ptr_t LastPtr = ptr_t'(DEPTH - 1);

  dtype            mem [DEPTH];
  ptr_t            rd_ptr;
  ptr_t            wr_ptr;
  logic [CntW-1:0] count;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CntW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_inorder_responder.sv
// Terminal AXI4+ATOP subordinate answering every transaction, in acceptance
// order, with a fixed response code and fixed read data while echoing IDs.
// Write IDs wait in WQ for their data, then in BQ for the B handshake; read
// bursts (and read-returning atomics) wait in RQ while R beats are counted.
module axi_inorder_responder
  import axi_inorder_responder_pkg::*;
#(
  parameter int unsigned AxiIdWidth   = DefIdWidth,
  parameter int unsigned AxiDataWidth = DefDataWidth,
  parameter int unsigned MaxTxns      = 4,
  parameter resp_t       RespCode     = RESP_DECERR,
  parameter logic [63:0] RespData     = 64'hCA11_AB1E_BAD_CAB1E,
  parameter type         axi_req_t    = axi_req_default_t,
  parameter type         axi_resp_t   = axi_resp_default_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o
);

  if (AxiIdWidth < 1) begin : g_bad_id_width
    $fatal(1, "axi_inorder_responder: AxiIdWidth must be at least 1");
  end
  if (AxiDataWidth < 8) begin : g_bad_data_width
    $fatal(1, "axi_inorder_responder: AxiDataWidth must be at least 8");
  end
  if (MaxTxns < 1) begin : g_bad_depth
    $fatal(1, "axi_inorder_responder: MaxTxns must be at least 1");
  end

  typedef logic [AxiIdWidth-1:0] id_t;
  typedef struct packed {
    id_t  id;
    len_t len;
  } rq_entry_t;

  localparam logic [AxiDataWidth-1:0] RData = AxiDataWidth'(RespData);

  logic      wq_full, wq_empty, wq_pop;
  id_t       wq_head;
  logic      bq_full, bq_empty, bq_pop;
  id_t       bq_head;
  logic      rq_full, rq_empty, rq_push, rq_pop;
  rq_entry_t rq_head, rq_din;

  logic aw_atop_r, aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last;
  logic aw_hs, ar_hs, w_hs, r_hs, aw_rq_push;
  len_t cnt;
  logic unused_req;

  // Every request bit is consumed somewhere; data, strobes and addresses are discarded.
  assign unused_req = ^slv_req_i;

  assign aw_atop_r = slv_req_i.aw.atop[ATOP_R_RESP];

  // Readies and valids are forced low while reset is sampled so nothing handshakes.
  assign aw_ready = rst_ni & ~wq_full & (~aw_atop_r | ~rq_full);
  assign ar_ready = rst_ni & ~rq_full & ~(slv_req_i.aw_valid & aw_atop_r);
  assign w_ready  = rst_ni & ~wq_empty & ~bq_full;
  assign b_valid  = rst_ni & ~bq_empty;
  assign r_valid  = rst_ni & ~rq_empty;
  assign r_last   = rst_ni & (cnt == rq_head.len);

  assign aw_hs      = slv_req_i.aw_valid & aw_ready;
  assign ar_hs      = slv_req_i.ar_valid & ar_ready;
  assign w_hs       = slv_req_i.w_valid & w_ready;
  assign r_hs       = r_valid & slv_req_i.r_ready;
  assign aw_rq_push = aw_hs & aw_atop_r;

  assign wq_pop  = w_hs & slv_req_i.w.last;
  assign bq_pop  = b_valid & slv_req_i.b_ready;
  assign rq_push = aw_rq_push | ar_hs;
  assign rq_pop  = r_hs & r_last;

  // Select the RQ entry source; an R-returning atomic blocks AR, so only one pushes.
  always_comb begin
    rq_din = '0;
    if (aw_rq_push) begin
      rq_din.id  = slv_req_i.aw.id;
      rq_din.len = slv_req_i.aw.len;
    end else begin
      rq_din.id  = slv_req_i.ar.id;
      rq_din.len = slv_req_i.ar.len;
    end
  end

  sync_fifo #(.DEPTH(MaxTxns), .dtype(id_t)) i_wq (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (aw_hs),
    .push_data (slv_req_i.aw.id),
    .pop       (wq_pop),
    .head      (wq_head),
    .full      (wq_full),
    .empty     (wq_empty)
  );

  sync_fifo #(.DEPTH(MaxTxns), .dtype(id_t)) i_bq (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (wq_pop),
    .push_data (wq_head),
    .pop       (bq_pop),
    .head      (bq_head),
    .full      (bq_full),
    .empty     (bq_empty)
  );

  sync_fifo #(.DEPTH(MaxTxns), .dtype(rq_entry_t)) i_rq (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (rq_push),
    .push_data (rq_din),
    .pop       (rq_pop),
    .head      (rq_head),
    .full      (rq_full),
    .empty     (rq_empty)
  );

  // Beat counter for the burst at the RQ head; cleared on the last beat so bursts chain.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (r_hs) begin
      cnt <= r_last ? '0 : cnt + 1'b1;
    end
  end

  // Assemble the response struct; IDs read zero while reset is sampled.
  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_ready;
    slv_resp_o.ar_ready = ar_ready;
    slv_resp_o.w_ready  = w_ready;
    slv_resp_o.b_valid  = b_valid;
    slv_resp_o.b.id     = rst_ni ? bq_head : '0;
    slv_resp_o.b.resp   = RespCode;
    slv_resp_o.b.user   = '0;
    slv_resp_o.r_valid  = r_valid;
    slv_resp_o.r.id     = rst_ni ? rq_head.id : '0;
    slv_resp_o.r.data   = RData;
    slv_resp_o.r.resp   = RespCode;
    slv_resp_o.r.last   = r_last;
    slv_resp_o.r.user   = '0;
  end

endmodule

// File: tb/tb_axi_inorder_responder.sv
// Scoreboard bench for the in-order responder: stimulus tasks queue the
// expected B IDs and R beats at each accepted address, and a monitor on the
// falling edge pops and compares every B/R handshake and checks stalled
// payloads stay put.
module tb_axi_inorder_responder;
  import axi_inorder_responder_pkg::*;

  localparam logic [63:0] ExpData = 64'hCA11AB1EBADCAB1E;
  localparam logic [1:0]  ExpResp = 2'b11;

  typedef struct {
    logic [3:0] id;
    logic       last;
  } exp_r_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  axi_req_default_t  req_drv;
  axi_req_default_t  req;
  axi_resp_default_t resp;
  logic              b_rdy, r_rdy;
  logic              b_hold = 1'b1;
  logic              r_hold = 1'b1;
  logic              rdy_mode = 1'b0;

  int checks = 0;
  int failures = 0;
  int lasts_done = 0;

  logic [3:0] exp_b [$];
  exp_r_t     exp_r [$];

  always #5 clk = ~clk;

  // Merge the stimulus-driven fields with the independently driven ready lines.
  always_comb begin
    req         = req_drv;
    req.b_ready = b_rdy;
    req.r_ready = r_rdy;
  end

  axi_inorder_responder #(
    .AxiIdWidth   (4),
    .AxiDataWidth (64),
    .MaxTxns      (4),
    .RespCode     (RESP_DECERR),
    .RespData     (64'hCA11_AB1E_BAD_CAB1E),
    .axi_req_t    (axi_req_default_t),
    .axi_resp_t   (axi_resp_default_t)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .slv_req_i  (req),
    .slv_resp_o (resp)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic failNote(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout expected=handshake", name);
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  // Ready lines: held values, or random toggling to exercise stalls.
  initial begin
    b_rdy = 1'b1;
    r_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) begin
        b_rdy = 1'($urandom_range(0, 1));
        r_rdy = 1'($urandom_range(0, 1));
      end else begin
        b_rdy = b_hold;
        r_rdy = r_hold;
      end
    end
  end

  // Monitor: compare each B/R handshake against the scoreboard and check stall stability.
  initial begin
    logic      r_stall, b_stall;
    r_chan_t   r_saved;
    b_chan_t   b_saved;
    exp_r_t    er;
    logic [3:0] eb;
    r_stall = 1'b0;
    b_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        r_stall = 1'b0;
        b_stall = 1'b0;
      end else begin
        if (r_stall) begin
          checkOutput("r_valid_held", resp.r_valid, 1);
          checkOutput("r_payload_stable", resp.r == r_saved, 1);
        end
        if (b_stall) begin
          checkOutput("b_valid_held", resp.b_valid, 1);
          checkOutput("b_payload_stable", resp.b == b_saved, 1);
        end
        if (resp.r_valid && r_rdy) begin
          if (exp_r.size() == 0) begin
            checkOutput("r_unexpected_beat", 1, 0);
          end else begin
            er = exp_r.pop_front();
            checkOutput("r_id", resp.r.id, er.id);
            checkOutput("r_data", resp.r.data, ExpData);
            checkOutput("r_resp", resp.r.resp, ExpResp);
            checkOutput("r_last", resp.r.last, er.last);
            if (resp.r.last) lasts_done++;
          end
        end
        if (resp.b_valid && b_rdy) begin
          if (exp_b.size() == 0) begin
            checkOutput("b_unexpected", 1, 0);
          end else begin
            eb = exp_b.pop_front();
            checkOutput("b_id", resp.b.id, eb);
            checkOutput("b_resp", resp.b.resp, ExpResp);
          end
        end
        r_stall = resp.r_valid & ~r_rdy;
        b_stall = resp.b_valid & ~b_rdy;
        r_saved = resp.r;
        b_saved = resp.b;
      end
    end
  end

  task automatic push_r(input logic [3:0] id, input logic [7:0] len);
    for (int b = 0; b <= int'(len); b++) begin
      exp_r.push_back('{id: id, last: (b == int'(len))});
    end
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [7:0] len, input logic [5:0] atop);
    logic hs;
    hs = 1'b0;
    req_drv.aw.id   = id;
    req_drv.aw.len  = len;
    req_drv.aw.atop = atop;
    req_drv.aw_valid = 1'b1;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk);
      if (resp.aw_ready) begin
        hs = 1'b1;
        exp_b.push_back(id);
        if (atop[5]) push_r(id, len);
      end
      wait_cycle();
    end
    req_drv.aw_valid = 1'b0;
    req_drv.aw.atop  = ATOP_NONE;
    if (!hs) failNote("aw_handshake");
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [7:0] len);
    logic hs;
    hs = 1'b0;
    req_drv.ar.id    = id;
    req_drv.ar.len   = len;
    req_drv.ar_valid = 1'b1;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk);
      if (resp.ar_ready) begin
        hs = 1'b1;
        push_r(id, len);
      end
      wait_cycle();
    end
    req_drv.ar_valid = 1'b0;
    if (!hs) failNote("ar_handshake");
  endtask

  task automatic send_w(input int beats);
    logic hs;
    for (int b = 0; b < beats; b++) begin
      hs = 1'b0;
      req_drv.w.data  = {$urandom, $urandom};
      req_drv.w.strb  = '1;
      req_drv.w.last  = (b == beats - 1);
      req_drv.w_valid = 1'b1;
      for (int i = 0; i < 200 && !hs; i++) begin
        @(negedge clk);
        if (resp.w_ready) hs = 1'b1;
        wait_cycle();
      end
      if (!hs) failNote("w_handshake");
    end
    req_drv.w_valid = 1'b0;
    req_drv.w.last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 1000 && (exp_b.size() != 0 || exp_r.size() != 0); i++) begin
      wait_cycle();
    end
    wait_cycle();
    wait_cycle();
    checkOutput({name, "_b_drained"}, 64'(exp_b.size()), 0);
    checkOutput({name, "_r_drained"}, 64'(exp_r.size()), 0);
  endtask

  task automatic applyStimulus();
    int base;
    req_drv = '0;
    rst_n = 1'b0;
    repeat (3) wait_cycle();
    @(negedge clk);
    checkOutput("reset_aw_ready", resp.aw_ready, 0);
    checkOutput("reset_ar_ready", resp.ar_ready, 0);
    checkOutput("reset_b_valid", resp.b_valid, 0);
    checkOutput("reset_r_valid", resp.r_valid, 0);
    wait_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_aw_ready", resp.aw_ready, 1);
    checkOutput("idle_ar_ready", resp.ar_ready, 1);
    checkOutput("idle_w_ready", resp.w_ready, 0);
    checkOutput("idle_b_valid", resp.b_valid, 0);
    checkOutput("idle_r_valid", resp.r_valid, 0);
    wait_cycle();

    $display("[TB] single write");
    send_aw(4'd5, 8'd3, ATOP_NONE);
    @(negedge clk);
    checkOutput("w_ready_after_aw", resp.w_ready, 1);
    wait_cycle();
    send_w(4);
    wait_drain("single_write");
    @(negedge clk);
    checkOutput("wq_empty_after_write", resp.w_ready, 0);
    checkOutput("bq_empty_after_write", resp.b_valid, 0);
    wait_cycle();

    $display("[TB] read burst with random ready");
    rdy_mode = 1'b1;
    send_ar(4'd2, 8'd7);
    wait_drain("read_burst");
    rdy_mode = 1'b0;
    b_hold = 1'b1;
    r_hold = 1'b0;
    repeat (3) wait_cycle();

    $display("[TB] ordering and full RQ");
    send_ar(4'd3, 8'd1);
    send_ar(4'd1, 8'd1);
    send_ar(4'd0, 8'd1);
    send_ar(4'd2, 8'd1);
    req_drv.ar.id    = 4'd5;
    req_drv.ar.len   = 8'd0;
    req_drv.ar_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("ar_ready_rq_full", resp.ar_ready, 0);
      wait_cycle();
    end
    base = lasts_done;
    r_hold = 1'b1;
    send_ar(4'd5, 8'd0);
    checkOutput("fifth_ar_after_first_last", 64'(lasts_done - base >= 1), 1);
    wait_drain("ordering");

    $display("[TB] atomic with simultaneous AR");
    fork
      send_aw(4'd7, 8'd0, 6'b100000);
      send_ar(4'd1, 8'd0);
      send_w(1);
      begin
        @(negedge clk);
        checkOutput("ar_stalled_by_atop", resp.ar_ready, 0);
        checkOutput("aw_ready_atop", resp.aw_ready, 1);
      end
    join
    wait_drain("atop");

    $display("[TB] early W");
    req_drv.w.data  = 64'h1234;
    req_drv.w.strb  = '1;
    req_drv.w.last  = 1'b1;
    req_drv.w_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("w_ready_before_aw", resp.w_ready, 0);
      wait_cycle();
    end
    send_aw(4'd9, 8'd0, ATOP_NONE);
    send_w(1);
    wait_drain("early_w");

    $display("[TB] reset mid R burst");
    send_ar(4'd6, 8'd7);
    wait_cycle();
    wait_cycle();
    rst_n = 1'b0;
    exp_r.delete();
    exp_b.delete();
    @(negedge clk);
    checkOutput("midreset_aw_ready", resp.aw_ready, 0);
    checkOutput("midreset_w_ready", resp.w_ready, 0);
    checkOutput("midreset_ar_ready", resp.ar_ready, 0);
    checkOutput("midreset_b_valid", resp.b_valid, 0);
    checkOutput("midreset_r_valid", resp.r_valid, 0);
    checkOutput("midreset_r_id", resp.r.id, 0);
    checkOutput("midreset_r_resp", resp.r.resp, ExpResp);
    checkOutput("midreset_r_data", resp.r.data, ExpData);
    wait_cycle();
    rst_n = 1'b1;
    send_ar(4'd4, 8'd1);
    wait_drain("after_reset");
    @(negedge clk);
    checkOutput("final_r_idle", resp.r_valid, 0);
  endtask

  initial begin
    applyStimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends even if a bound is missed.
  initial begin
    #2000000;
    failNote("global_watchdog");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
